// File: rtl/serial_accumulator.sv
// serial_accumulator: bit-serial 26-bit accumulator/adder stage.
// The accumulator is a right-rotating shift register. Each bit strobe
// combines acc[0] with the serial operand bit and inserts the result at the
// sign end, so one word operation takes exactly WIDTH strobes.
// Optional feature macro: SERIAL_ACC_XOR_EN (opcode 1001 performs XOR).
//
// state | meaning
// IDLE  | waiting for start; bit strobes ignored; acc and ovf held
// RUN   | word operation in progress; each strobe processes one bit
module serial_accumulator #(
  parameter int WIDTH = 26
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic             i_bit_strobe,
  input  logic             i_opnd_bit,
  output logic             o_acc_bit,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ovf
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0111;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSU = 4'b1101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_CLA = 4'b1111;
  localparam logic [3:0] OP_XOR = 4'b1001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;
  logic             r_done;
  logic             r_ovf;

  logic             w_a;
  logic             w_m;
  logic             w_x;
  logic             w_y;
  logic             w_r;
  logic             w_cout;
  logic             w_arith;
  logic             w_last;

  assign w_a    = r_acc[0];
  assign w_m    = i_opnd_bit;
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Next state and per-bit result: SUB/RSU reuse the adder with one operand
  // inverted and the carry preset to 1 at start.
  always_comb begin
    w_state_nxt = r_state;
    w_x         = w_a;
    w_y         = w_m;
    w_arith     = 1'b0;
    w_r         = w_a;
    w_cout      = r_carry;
    case (r_op)
      OP_ADD: begin
        w_arith = 1'b1;
      end
      OP_SUB: begin
        w_arith = 1'b1;
        w_y     = ~w_m;
      end
      OP_RSU: begin
        w_arith = 1'b1;
        w_x     = ~w_a;
      end
      default: ;
    endcase
    if (w_arith) begin
      w_r    = w_x ^ w_y ^ r_carry;
      w_cout = (w_x & w_y) | (w_x & r_carry) | (w_y & r_carry);
    end else begin
      case (r_op)
        OP_AND: w_r = w_a & w_m;
        OP_CLA: w_r = w_m;
`ifdef SERIAL_ACC_XOR_EN
        OP_XOR: w_r = w_a ^ w_m;
`endif
        default: w_r = w_a;
      endcase
    end
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = RUN;
      RUN:     if (i_bit_strobe && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Datapath: latch op/carry on accepted start, shift one bit per strobe in RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op    <= 4'b0000;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (i_start) begin
          r_op    <= i_op;
          r_carry <= (i_op == OP_SUB) || (i_op == OP_RSU);
          r_ovf   <= 1'b0;
          r_cnt   <= '0;
        end
      end else if (i_bit_strobe) begin
        r_acc   <= {w_r, r_acc[WIDTH-1:1]};
        r_carry <= w_cout;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_done <= 1'b1;
          // Carry into the sign bit versus carry out of it.
          r_ovf  <= w_arith & (r_carry ^ w_cout);
          r_cnt  <= '0;
        end
      end
    end
  end

  assign o_acc     = r_acc;
  assign o_acc_bit = r_acc[0];
  assign o_busy    = (r_state == RUN);
  assign o_done    = r_done;
  assign o_ovf     = r_ovf;

endmodule
